// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
package regfile_pkg;

   localparam int unsigned REG_WIDTH  = 64;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned XZR_IDX    = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_WIDTH-1:0]  reg_word_t;
   typedef reg_word_t [NUM_REGS-1:0] reg_bank_t;

endpackage

// File: rtl/reg_file_64x32_dec.sv
// 5:32 one-hot write-enable decoder. The bit for the zero register is never set.
module decoder5_32
   import regfile_pkg::*;
#(
   parameter int unsigned ZERO_IDX = XZR_IDX
) (
   input  logic                addr_en,
   input  reg_addr_t           addr,
   output logic [NUM_REGS-1:0] onehot
);

   // Enable bit i only when the index matches. An unknown enable can only touch the
   // addressed bit, because every other bit is ANDed with a false compare.
   always_comb begin
      // NOTE: the output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i != ZERO_IDX) begin
            onehot[i] = addr_en & (addr == REG_ADDR_W'(i));
         end
      end
   end

endmodule

// File: rtl/reg_file_64x32_mux.sv
// 32:1 read-select mux over the packed register bank; one instance per read port.
module mux32_1
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = REG_WIDTH
) (
   input  logic [NUM_REGS-1:0][WIDTH-1:0] bank,
   input  reg_addr_t                      sel,
   output logic [WIDTH-1:0]               data
);

   assign data = bank[sel];

endmodule

// File: rtl/reg_file_64x32.sv
// Architectural register file: X0..X30 in flops, X31 hard-wired to zero.
// One synchronous write port and two combinational read ports, with optional
// same-cycle write-to-read forwarding placed after each read mux.
module reg_file_64x32
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = REG_WIDTH,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned ZERO_REG = XZR_IDX,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [NUM_REGS-1:0]            we;
   logic [NUM_REGS-1:0][WIDTH-1:0] bank;
   logic [WIDTH-1:0]               mux_data1;
   logic [WIDTH-1:0]               mux_data2;
   logic                           hit1;
   logic                           hit2;

   decoder5_32 #(
      .ZERO_IDX (ZERO_REG)
   ) u_dec (
      .addr_en (wr_en),
      .addr    (wr_addr),
      .onehot  (we)
   );

   // Per-register storage: enabled DFFs, with the zero entry tied off in the bank.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == ZERO_REG) begin : g_zero
         assign bank[i] = '0;
      end else begin : g_dff
         logic [WIDTH-1:0] q;

         // Load wr_data when this register's decoded enable is high; reset clears it.
         always_ff @(posedge clk or posedge reset) begin
            // NOTE: every register clears on reset. These are discrete flops, not a RAM macro, and the read ports must show zero right after reset.
            if (reset) begin
               // NOTE: sequential state is assigned with <= so that all flops sample their pre-edge inputs together.
               q <= '0;
            end else if (we[i]) begin
               q <= wr_data;
            end
         end

         assign bank[i] = q;
      end
   end

   mux32_1 #(.WIDTH(WIDTH)) u_mux1 (.bank(bank), .sel(rd_addr1), .data(mux_data1));
   mux32_1 #(.WIDTH(WIDTH)) u_mux2 (.bank(bank), .sel(rd_addr2), .data(mux_data2));

   // Forward only a real write to a non-zero register on the same port's address.
   assign hit1 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1) && (rd_addr1 != ZERO_ADDR);
   assign hit2 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2) && (rd_addr2 != ZERO_ADDR);

   // Port 1 output: reset forces zero, otherwise a 2:1 bypass after the read mux.
   always_comb begin
      rd_data1 = mux_data1;
      if (reset) begin
         rd_data1 = '0;
      end else if (hit1) begin
         rd_data1 = wr_data;
      end
   end

   // Port 2 output: same structure as port 1, resolved independently.
   always_comb begin
      rd_data2 = mux_data2;
      if (reset) begin
         rd_data2 = '0;
      end else if (hit2) begin
         rd_data2 = wr_data;
      end
   end

endmodule

// File: tb/tb_reg_file_64x32.sv
// Directed bench for reg_file_64x32. Two instances share the stimulus:
// one with forwarding enabled and one with it disabled.
module tb_reg_file_64x32;
   import regfile_pkg::*;

   logic      clk = 1'b0;
   logic      reset;
   logic      wr_en;
   reg_addr_t wr_addr;
   reg_word_t wr_data;
   reg_addr_t rd_addr1;
   reg_addr_t rd_addr2;
   reg_word_t rd_data1;
   reg_word_t rd_data2;
   reg_word_t nb_data1;
   reg_word_t nb_data2;

   int tests = 0;
   int fails = 0;

   localparam reg_word_t PAT = 64'h0101_0101_0101_0101;

   typedef struct {
      logic      we;
      reg_addr_t wa;
      reg_word_t wd;
      reg_addr_t ra1;
      reg_addr_t ra2;
      reg_word_t e1;   // bypass instance, before the edge
      reg_word_t e2;
      reg_word_t n1;   // non-bypass instance, before the edge
      reg_word_t n2;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   reg_file_64x32 #(.BYPASS(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2)
   );

   reg_file_64x32 #(.BYPASS(0)) dut_nb (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (nb_data1),
      .rd_data2 (nb_data2)
   );

   task automatic check(input string name, input reg_word_t act, input reg_word_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply one set of inputs just after a falling edge, mid-cycle.
   task automatic drive(input logic we, input reg_addr_t wa, input reg_word_t wd,
                        input reg_addr_t ra1, input reg_addr_t ra2);
      @(negedge clk);
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rd_addr1 = ra1;
      rd_addr2 = ra2;
   endtask

   task automatic check_all(input string name, input reg_word_t e1, input reg_word_t e2,
                            input reg_word_t n1, input reg_word_t n2);
      check({name, "_p1"},    rd_data1, e1);
      check({name, "_p2"},    rd_data2, e2);
      check({name, "_nb_p1"}, nb_data1, n1);
      check({name, "_nb_p2"}, nb_data2, n2);
   endtask

   // Read every address through both ports and expect zero everywhere.
   task automatic read_all_zero(input string name);
      for (int i = 0; i < NUM_REGS; i++) begin
         drive(1'b0, 5'd0, '0, reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i));
         #1;
         check_all($sformatf("%s_%0d", name, i), '0, '0, '0, '0);
      end
   endtask

   function automatic reg_word_t sweep_val(input int i);
      return reg_word_t'(i) * PAT;
   endfunction

   initial begin
      vecs[0]  = '{1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, 5'd5,  5'd4,
                   64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0};
      vecs[1]  = '{1'b0, 5'd0,  64'h0, 5'd5, 5'd6,
                   64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0};
      vecs[2]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5,
                   64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF};
      vecs[3]  = '{1'b0, 5'd0,  64'h0, 5'd31, 5'd30, 64'h0, 64'h0, 64'h0, 64'h0};
      vecs[4]  = '{1'b1, 5'd7,  64'h11, 5'd7, 5'd7, 64'h11, 64'h11, 64'h0, 64'h0};
      vecs[5]  = '{1'b1, 5'd7,  64'h22, 5'd7, 5'd7, 64'h22, 64'h22, 64'h11, 64'h11};
      vecs[6]  = '{1'b0, 5'd7,  64'h0, 5'd7, 5'd7, 64'h22, 64'h22, 64'h22, 64'h22};
      vecs[7]  = '{1'b1, 5'd3,  64'hAAAA, 5'd3, 5'd4, 64'hAAAA, 64'h0, 64'h0, 64'h0};
      vecs[8]  = '{1'b0, 5'd3,  64'hDEAD, 5'd3, 5'd3, 64'hAAAA, 64'hAAAA, 64'hAAAA, 64'hAAAA};
      vecs[9]  = '{1'b0, 5'd0,  64'h0, 5'd3, 5'd0, 64'hAAAA, 64'h0, 64'hAAAA, 64'h0};
      vecs[10] = '{1'b1, 5'd0,  64'h5555, 5'd0, 5'd1, 64'h5555, 64'h0, 64'h0, 64'h0};
      vecs[11] = '{1'b0, 5'd0,  64'h0, 5'd0, 5'd7, 64'h5555, 64'h22, 64'h5555, 64'h22};

      reset    = 1'b1;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr1 = 5'd5;
      rd_addr2 = 5'd31;
      #2;
      check_all("in_reset", '0, '0, '0, '0);

      @(negedge clk);
      reset = 1'b0;
      read_all_zero("post_reset");

      // Table-driven single-cycle vectors, checked before each write edge.
      for (int v = 0; v < $size(vecs); v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
         #1;
         check_all($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].n1, vecs[v].n2);
      end

      // Reset asserted mid-cycle with a write pending: outputs drop at once,
      // the write across the next edge is discarded.
      drive(1'b1, 5'd5, 64'hFFFF_0000_FFFF_0000, 5'd5, 5'd7);
      #3;
      reset = 1'b1;
      #1;
      check_all("async_reset", '0, '0, '0, '0);
      @(negedge clk);
      wr_en = 1'b0;
      reset = 1'b0;
      read_all_zero("after_reset");

      // Sweep: fill X0..X30, then read mirrored pairs.
      for (int i = 0; i <= 30; i++) begin
         drive(1'b1, reg_addr_t'(i), sweep_val(i), 5'd31, 5'd31);
      end
      for (int i = 0; i <= 30; i++) begin
         drive(1'b0, 5'd0, '0, reg_addr_t'(i), reg_addr_t'(30 - i));
         #1;
         check_all($sformatf("sweep_%0d", i), sweep_val(i), sweep_val(30 - i),
                   sweep_val(i), sweep_val(30 - i));
         if (i == 15) begin
            #2;
            reset = 1'b1;
            #1;
            check_all("sweep_reset", '0, '0, '0, '0);
            @(negedge clk);
            reset = 1'b0;
            break;
         end
      end
      drive(1'b0, 5'd0, '0, 5'd31, 5'd30);
      #1;
      check_all("sweep_zero_reg", '0, '0, '0, '0);
      read_all_zero("post_sweep");

      // An unknown write enable must not disturb a register it does not address.
      drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd31, 5'd31);
      drive(1'bx, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
      drive(1'b0, 5'd0, '0, 5'd5, 5'd4);
      #1;
      check_all("x_enable", 64'h0123_4567_89AB_CDEF, '0, 64'h0123_4567_89AB_CDEF, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
